// File: rtl/wb_arb.sv
// wb_arb: shares the single integer register-file write port between the
// in-order writeback path (A) and a buffered long-latency producer (B).
// A has priority unless the B FIFO is full or B has waited STARVE_MAX
// A grants. Also exports which registers have a queued B write pending.
module wb_arb #(
   parameter int REG_WIDTH  = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // requester A: in-order writeback
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [4:0]           a_rd,
   input  logic [REG_WIDTH-1:0] a_data,
   // requester B: long-latency producer
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [4:0]           b_rd,
   input  logic [REG_WIDTH-1:0] b_data,
   // register-file write port
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [REG_WIDTH-1:0] rf_wdata,
   // hazard / status
   output logic [31:0]          pend_vec,
   output logic                 b_starving
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_MAX_C = CW'(STARVE_MAX);
   // Pointers that differ only in the wrap bit mean the FIFO is full.
   localparam logic [AW:0]   FULL_XOR     = {1'b1, {AW{1'b0}}};

   // FIFO state
   logic [AW:0]          wr_ptr_q, wr_ptr_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [4:0]           fifo_rd_q   [FIFO_DEPTH];
   logic [REG_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

   // starvation counter
   logic [CW-1:0]        starve_cnt_q, starve_cnt_d;

   // registered write port
   logic                 rf_we_q, rf_we_d;
   logic [4:0]           rf_waddr_q, rf_waddr_d;
   logic [REG_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

   // combinational control
   logic                 full, empty, push, pop;
   logic                 grant_a, grant_b, granted;
   logic [AW:0]          count;
   logic [4:0]           head_rd, sel_rd;
   logic [REG_WIDTH-1:0] head_data, sel_data;
   logic [AW-1:0]        slot;
   logic [31:0]          pend;

   // FIFO status, head entry and starvation flag from registered state
   always_comb begin
      empty      = (wr_ptr_q == rd_ptr_q);
      full       = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
      count      = wr_ptr_q - rd_ptr_q;
      head_rd    = fifo_rd_q[rd_ptr_q[AW-1:0]];
      head_data  = fifo_data_q[rd_ptr_q[AW-1:0]];
      b_starving = (starve_cnt_q == STARVE_MAX_C);
   end

   // Arbitration: B wins when A is idle, the FIFO is full, or B is starving
   always_comb begin
      grant_b  = !empty && (!a_valid || full || b_starving);
      grant_a  = a_valid && !grant_b;
      granted  = grant_a || grant_b;
      pop      = grant_b;
      // A full FIFO refuses B even if it pops this cycle: no pass-through.
      b_ready  = !full;
      push     = b_valid && b_ready;
      a_ready  = grant_a;
      sel_rd   = grant_b ? head_rd   : a_rd;
      sel_data = grant_b ? head_data : a_data;
   end

   // Next pointer values
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   // Starvation counter: counts A grants that bypass a waiting B entry
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_b) begin
         starve_cnt_d = '0;
      end else if (grant_a) begin
         if (!empty) begin
            if (!b_starving) begin
               starve_cnt_d = starve_cnt_q + CW'(1);
            end
         end else begin
            starve_cnt_d = '0;
         end
      end
   end

   // Write-port stage: x0 writes are accepted but never reach the register
   // file, and the address/data hold their last real write
   always_comb begin
      rf_we_d    = granted && (sel_rd != 5'd0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (rf_we_d) begin
         rf_waddr_d = sel_rd;
         rf_wdata_d = sel_data;
      end
   end

   // Pending-destination vector over the valid FIFO entries only
   always_comb begin
      pend = '0;
      slot = '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         slot = rd_ptr_q[AW-1:0] + AW'(k);
         if ((AW+1)'(k) < count) begin
            pend[fifo_rd_q[slot]] = 1'b1;
         end
      end
      // x0 is never written, so it can never be a hazard.
      pend[0]  = 1'b0;
      pend_vec = pend;
   end

   // Control state register: pointers, counter and write port
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values computed by the combinational blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         starve_cnt_q <= '0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   // FIFO storage written on push
   // NOTE: the storage array has no reset; reset empties the FIFO through
   // the pointers and stale entries are never read as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q[AW-1:0]]   <= b_rd;
         fifo_data_q[wr_ptr_q[AW-1:0]] <= b_data;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed scenarios plus a randomized run
// against a queue-based behavioural model of the arbitration rules.
module tb_wb_arb;

   localparam int W     = 32;
   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_valid, b_valid;
   logic          a_ready, b_ready;
   logic [4:0]    a_rd, b_rd;
   logic [W-1:0]  a_data, b_data;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [W-1:0]  rf_wdata;
   logic [31:0]   pend_vec;
   logic          b_starving;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]   rd;
      logic [W-1:0] data;
   } b_ent_t;

   wb_arb #(.REG_WIDTH(W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .pend_vec   (pend_vec),
      .b_starving (b_starving)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
   endtask

   function automatic logic [4:0] rnd_rd();
      if ($urandom_range(0, 5) == 0) return 5'd0;
      return 5'($urandom_range(1, 31));
   endfunction

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #2;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
      checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
      checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
      checks++; if (pend_vec !== 32'd0) begin errors++; $display("FAIL reset_pend_vec: got %h want 0", pend_vec); end
      checks++; if (b_starving !== 1'b0) begin errors++; $display("FAIL reset_b_starving: got %b want 0", b_starving); end
      a_valid = 1'b1; #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready_hi: got %b want 1", a_ready); end
      a_valid = 1'b0; #1;
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready_lo: got %b want 0", a_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_a_only();
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready: got %b want 1", a_ready); end
      tick();
      idle();
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL a_only_we: got %b want 1", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL a_only_waddr: got %0d want 5", rf_waddr); end
      checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL a_only_wdata: got %h want 1234", rf_wdata); end
   endtask

   task automatic test_x0_drop();
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", a_ready); end
      tick();
      idle();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL x0_waddr_hold: got %0d want 5", rf_waddr); end
      checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL x0_wdata_hold: got %h want 1234", rf_wdata); end
   endtask

   task automatic test_b_idle_drain();
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hAA;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL bidle_ready: got %b want 1", b_ready); end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bidle_a_ready: got %b want 0", a_ready); end
      tick();
      idle();
      checks++; if (pend_vec !== 32'h80) begin errors++; $display("FAIL bidle_pend_set: got %h want 80", pend_vec); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bidle_we_early: got %b want 0", rf_we); end
      tick();
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL bidle_we: got %b want 1", rf_we); end
      checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL bidle_waddr: got %0d want 7", rf_waddr); end
      checks++; if (rf_wdata !== 32'hAA) begin errors++; $display("FAIL bidle_wdata: got %h want aa", rf_wdata); end
      checks++; if (pend_vec !== 32'h0) begin errors++; $display("FAIL bidle_pend_clr: got %h want 0", pend_vec); end
   endtask

   task automatic test_starvation();
      a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA0;
      b_valid = 1'b1; b_rd = 5'd9;  b_data = 32'hB9;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL starve_push_a_ready: got %b want 1", a_ready); end
      tick();
      b_valid = 1'b0;
      for (int i = 1; i <= SMAX; i++) begin
         #1;
         checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL starve_a_ready_%0d: got %b want 1", i, a_ready); end
         checks++; if (b_starving !== 1'b0) begin errors++; $display("FAIL starve_flag_%0d: got %b want 0", i, b_starving); end
         tick();
         checks++; if (rf_waddr !== 5'd10) begin errors++; $display("FAIL starve_a_waddr_%0d: got %0d want 10", i, rf_waddr); end
      end
      #1;
      checks++; if (b_starving !== 1'b1) begin errors++; $display("FAIL starve_flag_set: got %b want 1", b_starving); end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL starve_a_blocked: got %b want 0", a_ready); end
      checks++; if (pend_vec !== 32'h200) begin errors++; $display("FAIL starve_pend: got %h want 200", pend_vec); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin errors++; $display("FAIL starve_b_write: got we=%b addr=%0d want we=1 addr=9", rf_we, rf_waddr); end
      checks++; if (rf_wdata !== 32'hB9) begin errors++; $display("FAIL starve_b_wdata: got %h want b9", rf_wdata); end
      checks++; if (a_ready !== 1'b1 || b_starving !== 1'b0) begin errors++; $display("FAIL starve_resume: got a_ready=%b starving=%b want 1/0", a_ready, b_starving); end
      tick();
      idle();
      checks++; if (rf_waddr !== 5'd10) begin errors++; $display("FAIL starve_a_after: got %0d want 10", rf_waddr); end
   endtask

   task automatic test_full_fifo();
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
      b_valid = 1'b1; b_rd = 5'd1; b_data = 32'h11;
      tick();
      b_rd = 5'd2; b_data = 32'h22;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL full_second_push: got a_ready=%b b_ready=%b want 1/1", a_ready, b_ready); end
      tick();
      // FIFO now full; this B offer must be refused.
      b_rd = 5'd4; b_data = 32'h44;
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_b_ready: got %b want 0", b_ready); end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL full_a_blocked: got %b want 0", a_ready); end
      checks++; if (pend_vec !== 32'h6) begin errors++; $display("FAIL full_pend: got %h want 6", pend_vec); end
      tick();
      idle();
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin errors++; $display("FAIL full_first_pop: got we=%b addr=%0d want 1/1", rf_we, rf_waddr); end
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_b_ready_back: got %b want 1", b_ready); end
      checks++; if (pend_vec !== 32'h4) begin errors++; $display("FAIL full_pend_one: got %h want 4", pend_vec); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin errors++; $display("FAIL full_second_pop: got we=%b addr=%0d data=%h want 1/2/22", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pend_vec !== 32'h0) begin errors++; $display("FAIL full_pend_empty: got %h want 0", pend_vec); end
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_no_passthrough: got we=%b addr=%0d want we=0", rf_we, rf_waddr); end
   endtask

   task automatic test_async_reset();
      a_valid = 1'b1; a_rd = 5'd11; a_data = 32'hC11;
      b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hC12;
      tick();
      b_rd = 5'd13; b_data = 32'hC13;
      tick();
      idle();
      #1;
      checks++; if (rf_we !== 1'b1 || pend_vec !== 32'h3000 || b_ready !== 1'b0) begin errors++; $display("FAIL arst_pre: got we=%b pend=%h b_ready=%b want 1/3000/0", rf_we, pend_vec, b_ready); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL arst_we: got %b want 0", rf_we); end
      checks++; if (pend_vec !== 32'h0) begin errors++; $display("FAIL arst_pend: got %h want 0", pend_vec); end
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL arst_b_ready: got %b want 1", b_ready); end
      checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL arst_waddr: got %0d want 0", rf_waddr); end
      #1;
      rst_n = 1'b1;
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL arst_after_we: got %b want 0", rf_we); end
   endtask

   task automatic test_random(input int n);
      b_ent_t       q[$];
      b_ent_t       e;
      int           wait_cnt;
      logic         m_full, m_empty, m_starv, ga, gb, m_we;
      logic [4:0]   m_waddr, sel_rd;
      logic [W-1:0] m_wdata, sel_data;
      logic [31:0]  m_pend;
      idle();
      rst_n = 1'b0; #1; rst_n = 1'b1;
      wait_cnt = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      tick();
      for (int i = 0; i < n; i++) begin
         a_valid = ($urandom_range(0, 9) < 7);
         a_rd    = rnd_rd();
         a_data  = $urandom;
         b_valid = 1'($urandom_range(0, 1));
         b_rd    = rnd_rd();
         b_data  = $urandom;
         #1;
         m_full  = (q.size() == DEPTH);
         m_empty = (q.size() == 0);
         m_starv = (wait_cnt == SMAX);
         gb      = !m_empty && (!a_valid || m_full || m_starv);
         ga      = a_valid && !gb;
         m_pend  = '0;
         foreach (q[j]) m_pend[q[j].rd] = 1'b1;
         m_pend[0] = 1'b0;
         checks++; if (a_ready !== ga) begin errors++; $display("FAIL rnd_a_ready @%0d: got %b want %b", i, a_ready, ga); end
         checks++; if (b_ready !== !m_full) begin errors++; $display("FAIL rnd_b_ready @%0d: got %b want %b", i, b_ready, !m_full); end
         checks++; if (b_starving !== m_starv) begin errors++; $display("FAIL rnd_starving @%0d: got %b want %b", i, b_starving, m_starv); end
         checks++; if (pend_vec !== m_pend) begin errors++; $display("FAIL rnd_pend @%0d: got %h want %h", i, pend_vec, m_pend); end
         sel_rd = a_rd; sel_data = a_data;
         if (gb) begin
            e = q.pop_front();
            sel_rd = e.rd; sel_data = e.data;
         end
         m_we = (ga || gb) && (sel_rd != 5'd0);
         if (m_we) begin
            m_waddr = sel_rd; m_wdata = sel_data;
         end
         if (b_valid && !m_full) q.push_back('{rd: b_rd, data: b_data});
         if (gb) wait_cnt = 0;
         else if (ga && !m_empty) wait_cnt = (wait_cnt < SMAX) ? wait_cnt + 1 : SMAX;
         else if (ga) wait_cnt = 0;
         tick();
         checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_we @%0d: got %b want %b", i, rf_we, m_we); end
         checks++; if (rf_waddr !== m_waddr) begin errors++; $display("FAIL rnd_waddr @%0d: got %0d want %0d", i, rf_waddr, m_waddr); end
         checks++; if (rf_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata @%0d: got %h want %h", i, rf_wdata, m_wdata); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_x0_drop();
      test_b_idle_drain();
      test_starvation();
      test_full_fifo();
      test_async_reset();
      test_random(600);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
